// File: rtl/rv32_pkg.sv
// ---------------------------------------------------------------------------
// rv32_pkg
// Shared types and constants for the RV32 M-extension divide unit.
//   div_op_t    : operation encoding, equal to funct3[1:0]
//   div_state_t : divider sequencer states
//   DIV_CYCLES  : iteration count for the default configuration
// ---------------------------------------------------------------------------
package rv32_pkg;

   localparam int DEF_XLEN           = 32;
   localparam int DEF_BITS_PER_CYCLE = 1;

   // Number of CALC cycles for a given width and radix.
   function automatic int div_cycles(input int xlen, input int bits_per_cycle);
      return xlen / bits_per_cycle;
   endfunction

   localparam int DIV_CYCLES = div_cycles(DEF_XLEN, DEF_BITS_PER_CYCLE);

   typedef enum logic [1:0] {
      DIV  = 2'b00,
      DIVU = 2'b01,
      REM  = 2'b10,
      REMU = 2'b11
   } div_op_t;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      CALC = 2'b01,
      DONE = 2'b10
   } div_state_t;

endpackage

// File: rtl/rv32_div_step.sv
// ---------------------------------------------------------------------------
// rv32_div_step
// Combinational restoring shift-subtract block: resolves BITS_PER_CYCLE
// quotient bits per call. The quotient register starts holding the dividend
// magnitude and is shifted out into the partial remainder MSB first.
//   rem_i / rem_o : partial remainder in / out (always < div_i)
//   quo_i / quo_o : dividend-then-quotient shift register in / out
//   div_i         : divisor magnitude (non-zero on this path)
// ---------------------------------------------------------------------------
module rv32_div_step #(
   parameter int XLEN           = 32,
   parameter int BITS_PER_CYCLE = 1
) (
   input  logic [XLEN-1:0] rem_i,
   input  logic [XLEN-1:0] quo_i,
   input  logic [XLEN-1:0] div_i,
   output logic [XLEN-1:0] rem_o,
   output logic [XLEN-1:0] quo_o
);

   logic [XLEN-1:0] rem_s;
   logic [XLEN-1:0] quo_s;
   logic [XLEN:0]   part_s;
   logic [XLEN:0]   diff_s;

   // Unrolled restoring iterations; the partial value needs one extra bit
   // because remainder < divisor implies shifted remainder < 2*divisor.
   always_comb begin
      rem_s  = rem_i;
      quo_s  = quo_i;
      part_s = {(XLEN+1){1'b0}};
      diff_s = {(XLEN+1){1'b0}};
      for (int i = 0; i < BITS_PER_CYCLE; i++) begin
         part_s = {rem_s, quo_s[XLEN-1]};
         diff_s = part_s - {1'b0, div_i};
         quo_s  = {quo_s[XLEN-2:0], 1'b0};
         if (part_s >= {1'b0, div_i}) begin
            rem_s    = diff_s[XLEN-1:0];
            quo_s[0] = 1'b1;
         end else begin
            rem_s    = part_s[XLEN-1:0];
         end
      end
   end

   assign rem_o = rem_s;
   assign quo_o = quo_s;

endmodule

// File: rtl/rv32_div_unit.sv
// ---------------------------------------------------------------------------
// rv32_div_unit
// Iterative, decoupled DIV/DIVU/REM/REMU unit running beside the execute
// stage. Operands are captured on start_i, the result is returned through a
// done/ready handshake, and the in-flight rd is exported for hazard checks.
// Optional build macro: RV32_DIV_EARLY_OUT_EN (|dividend| < |divisor| is
// finished in one cycle instead of the full iteration count).
//   clk_i, rst_i                 : clock, synchronous active-high reset
//   start_i, op_i, rs1/rs2_data_i, rd_i : issue interface
//   kill_i                       : flush, abandons any division
//   ovr_valid_i, ovr_rd_i        : younger write to the same rd kills result
//   done_ready_i                 : downstream accepts the result
//   busy_o, pending_rd_o         : hazard interface
//   done_o, result_o, rd_o       : result interface (held until transfer)
// ---------------------------------------------------------------------------
module rv32_div_unit
   import rv32_pkg::*;
#(
   parameter int XLEN           = 32,
   parameter int BITS_PER_CYCLE = 1,
   parameter int RD_WIDTH       = 5
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                start_i,
   input  logic [1:0]          op_i,
   input  logic [XLEN-1:0]     rs1_data_i,
   input  logic [XLEN-1:0]     rs2_data_i,
   input  logic [RD_WIDTH-1:0] rd_i,
   input  logic                kill_i,
   input  logic                ovr_valid_i,
   input  logic [RD_WIDTH-1:0] ovr_rd_i,
   input  logic                done_ready_i,
   output logic                busy_o,
   output logic [RD_WIDTH-1:0] pending_rd_o,
   output logic                done_o,
   output logic [XLEN-1:0]     result_o,
   output logic [RD_WIDTH-1:0] rd_o
);

   localparam int N  = XLEN / BITS_PER_CYCLE;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   div_state_t          state_q;
   logic                busy_q;
   logic                done_q;
   logic [RD_WIDTH-1:0] pending_rd_q;
   logic [RD_WIDTH-1:0] rd_q;
   logic [XLEN-1:0]     result_q;
   logic [XLEN-1:0]     rem_q;
   logic [XLEN-1:0]     quo_q;
   logic [XLEN-1:0]     div_q;
   logic [CW-1:0]       cnt_q;
   logic                q_neg_q;
   logic                r_neg_q;
   logic                is_rem_q;

   div_op_t             op_s;
   logic                is_signed_s;
   logic                is_rem_s;
   logic                a_neg_s;
   logic                b_neg_s;
   logic [XLEN-1:0]     a_abs_s;
   logic [XLEN-1:0]     b_abs_s;
   logic                b_zero_s;
   logic                ovf_s;
   logic                early_s;
   logic [XLEN-1:0]     spec_res_s;
   logic [XLEN-1:0]     step_rem_s;
   logic [XLEN-1:0]     step_quo_s;
   logic [XLEN-1:0]     fin_res_s;
   logic                abort_s;

   // Issue-side decode: magnitudes, signs and the single-cycle special cases.
   always_comb begin
      op_s = div_op_t'(op_i);
      case (op_s)
         DIV:     begin is_signed_s = 1'b1; is_rem_s = 1'b0; end
         DIVU:    begin is_signed_s = 1'b0; is_rem_s = 1'b0; end
         REM:     begin is_signed_s = 1'b1; is_rem_s = 1'b1; end
         REMU:    begin is_signed_s = 1'b0; is_rem_s = 1'b1; end
         default: begin is_signed_s = 1'b0; is_rem_s = 1'b0; end
      endcase
      a_neg_s  = is_signed_s & rs1_data_i[XLEN-1];
      b_neg_s  = is_signed_s & rs2_data_i[XLEN-1];
      a_abs_s  = a_neg_s ? ({XLEN{1'b0}} - rs1_data_i) : rs1_data_i;
      b_abs_s  = b_neg_s ? ({XLEN{1'b0}} - rs2_data_i) : rs2_data_i;
      b_zero_s = (rs2_data_i == {XLEN{1'b0}});
      ovf_s    = is_signed_s && (rs1_data_i == {1'b1, {(XLEN-1){1'b0}}})
                 && (rs2_data_i == {XLEN{1'b1}});
`ifdef RV32_DIV_EARLY_OUT_EN
      early_s  = !b_zero_s && (a_abs_s < b_abs_s);
`else
      early_s  = 1'b0;
`endif
      // In the overflow case the quotient equals the dividend (most-negative).
      if (b_zero_s) begin
         spec_res_s = is_rem_s ? rs1_data_i : {XLEN{1'b1}};
      end else if (ovf_s) begin
         spec_res_s = is_rem_s ? {XLEN{1'b0}} : rs1_data_i;
      end else begin
         spec_res_s = is_rem_s ? rs1_data_i : {XLEN{1'b0}};
      end
   end

   rv32_div_step #(
      .XLEN           (XLEN),
      .BITS_PER_CYCLE (BITS_PER_CYCLE)
   ) u_step (
      .rem_i (rem_q),
      .quo_i (quo_q),
      .div_i (div_q),
      .rem_o (step_rem_s),
      .quo_o (step_quo_s)
   );

   // Sign correction of the last step's output and the discard condition.
   always_comb begin
      if (is_rem_q) begin
         fin_res_s = r_neg_q ? ({XLEN{1'b0}} - step_rem_s) : step_rem_s;
      end else begin
         fin_res_s = q_neg_q ? ({XLEN{1'b0}} - step_quo_s) : step_quo_s;
      end
      abort_s = kill_i | (ovr_valid_i & (ovr_rd_i == pending_rd_q));
   end

   // Sequencer with all outputs held in registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= IDLE;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         pending_rd_q <= {RD_WIDTH{1'b0}};
         rd_q         <= {RD_WIDTH{1'b0}};
         result_q     <= {XLEN{1'b0}};
         rem_q        <= {XLEN{1'b0}};
         quo_q        <= {XLEN{1'b0}};
         div_q        <= {XLEN{1'b0}};
         cnt_q        <= {CW{1'b0}};
         q_neg_q      <= 1'b0;
         r_neg_q      <= 1'b0;
         is_rem_q     <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               // A write to x0 is architecturally dead, so it is never issued.
               if (start_i && (rd_i != {RD_WIDTH{1'b0}})) begin
                  busy_q       <= 1'b1;
                  pending_rd_q <= rd_i;
                  if (b_zero_s || ovf_s || early_s) begin
                     state_q  <= DONE;
                     done_q   <= 1'b1;
                     result_q <= spec_res_s;
                     rd_q     <= rd_i;
                  end else begin
                     state_q  <= CALC;
                     rem_q    <= {XLEN{1'b0}};
                     quo_q    <= a_abs_s;
                     div_q    <= b_abs_s;
                     cnt_q    <= CW'(N - 1);
                     q_neg_q  <= a_neg_s ^ b_neg_s;
                     r_neg_q  <= a_neg_s;
                     is_rem_q <= is_rem_s;
                  end
               end
            end
            CALC: begin
               if (abort_s) begin
                  state_q      <= IDLE;
                  busy_q       <= 1'b0;
                  pending_rd_q <= {RD_WIDTH{1'b0}};
               end else begin
                  rem_q <= step_rem_s;
                  quo_q <= step_quo_s;
                  if (cnt_q == {CW{1'b0}}) begin
                     state_q  <= DONE;
                     done_q   <= 1'b1;
                     result_q <= fin_res_s;
                     rd_q     <= pending_rd_q;
                  end else begin
                     cnt_q <= cnt_q - {{(CW-1){1'b0}}, 1'b1};
                  end
               end
            end
            DONE: begin
               // Transfer and discard both leave; abort_s covers kill priority.
               if (abort_s || done_ready_i) begin
                  state_q      <= IDLE;
                  busy_q       <= 1'b0;
                  done_q       <= 1'b0;
                  pending_rd_q <= {RD_WIDTH{1'b0}};
                  rd_q         <= {RD_WIDTH{1'b0}};
                  result_q     <= {XLEN{1'b0}};
               end
            end
            default: begin
               state_q      <= IDLE;
               busy_q       <= 1'b0;
               done_q       <= 1'b0;
               pending_rd_q <= {RD_WIDTH{1'b0}};
               rd_q         <= {RD_WIDTH{1'b0}};
               result_q     <= {XLEN{1'b0}};
            end
         endcase
      end
   end

   assign busy_o       = busy_q;
   assign done_o       = done_q;
   assign pending_rd_o = pending_rd_q;
   assign rd_o         = rd_q;
   assign result_o     = result_q;

endmodule

// File: tb/tb_rv32_div_unit.sv
// ---------------------------------------------------------------------------
// tb_rv32_div_unit
// Self-checking bench for rv32_div_unit (default parameters). Expected
// results come from plain SystemVerilog division with the RISC-V special
// cases applied on top; expected latency from the operand class.
// Honours RV32_DIV_EARLY_OUT_EN for the expected latency.
// ---------------------------------------------------------------------------
module tb_rv32_div_unit;

   localparam int N_CYC = 32;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [1:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic [4:0]  rd;
   logic        kill;
   logic        ovr_valid;
   logic [4:0]  ovr_rd;
   logic        ready;
   logic        busy;
   logic [4:0]  pending_rd;
   logic        done;
   logic [31:0] result;
   logic [4:0]  rd_out;

   int checks   = 0;
   int failures = 0;

   rv32_div_unit #(.XLEN(32), .BITS_PER_CYCLE(1), .RD_WIDTH(5)) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .start_i      (start),
      .op_i         (op),
      .rs1_data_i   (a),
      .rs2_data_i   (b),
      .rd_i         (rd),
      .kill_i       (kill),
      .ovr_valid_i  (ovr_valid),
      .ovr_rd_i     (ovr_rd),
      .done_ready_i (ready),
      .busy_o       (busy),
      .pending_rd_o (pending_rd),
      .done_o       (done),
      .result_o     (result),
      .rd_o         (rd_out)
   );

   always #5 clk = ~clk;

   initial begin
      #3000000;
      $display("FAIL watchdog checks=%0d", checks);
      $fatal(1, "watchdog expired");
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // RISC-V M-extension semantics.
   function automatic logic [31:0] ref_result(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
      logic is_rem;
      logic is_signed;
      is_rem    = o[1];
      is_signed = !o[0];
      if (y == 32'd0)
         return is_rem ? x : 32'hFFFF_FFFF;
      if (is_signed && x == 32'h8000_0000 && y == 32'hFFFF_FFFF)
         return is_rem ? 32'd0 : 32'h8000_0000;
      if (is_signed)
         return is_rem ? 32'($signed(x) % $signed(y)) : 32'($signed(x) / $signed(y));
      return is_rem ? (x % y) : (x / y);
   endfunction

   function automatic int ref_latency(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
      logic [31:0] ux;
      logic [31:0] uy;
      if (y == 32'd0) return 1;
      if (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 1;
      ux = (!o[0] && x[31]) ? (32'd0 - x) : x;
      uy = (!o[0] && y[31]) ? (32'd0 - y) : y;
`ifdef RV32_DIV_EARLY_OUT_EN
      if (ux < uy) return 1;
`else
      if (ux < uy) return N_CYC + 1;
`endif
      return N_CYC + 1;
   endfunction

   // Called at a negedge; issues one op, checks latency, holding and transfer.
   task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [4:0] r, input int hold);
      int          lat;
      logic [31:0] exp_res;
      exp_res = ref_result(o, x, y);
      check_eq("idle_before_start", {31'd0, busy}, 32'd0);
      op = o; a = x; b = y; rd = r; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat = 1;
      check_eq("pending_rd", {27'd0, pending_rd}, {27'd0, r});
      while (!done && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      check_eq("latency", lat, ref_latency(o, x, y));
      check_eq("result", result, exp_res);
      check_eq("rd_o", {27'd0, rd_out}, {27'd0, r});
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check_eq("hold_done", {31'd0, done}, 32'd1);
         check_eq("hold_result", result, exp_res);
         check_eq("hold_rd", {27'd0, rd_out}, {27'd0, r});
      end
      ready = 1'b1;
      @(negedge clk);
      ready = 1'b0;
      check_eq("post_xfer_done", {31'd0, done}, 32'd0);
      check_eq("post_xfer_busy", {31'd0, busy}, 32'd0);
   endtask

   // Waits a while and checks that no result ever appears.
   task automatic expect_no_done(input string tag);
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done) seen = 1'b1;
      end
      check_eq(tag, {31'd0, seen}, 32'd0);
   endtask

   // Issue rd=10 at T, discard at T+5 by override or kill.
   task automatic abort_test(input bit use_kill);
      check_eq("abort_idle", {31'd0, busy}, 32'd0);
      op = 2'b01; a = 32'd1000; b = 32'd7; rd = 5'd10; start = 1'b1;
      @(negedge clk);                 // now in cycle T+1
      start = 1'b0;
      ovr_valid = 1'b1; ovr_rd = 5'd11; // different rd must not discard
      @(negedge clk);                 // T+2
      ovr_valid = 1'b0;
      check_eq("ovr_other_rd_busy", {31'd0, busy}, 32'd1);
      repeat (3) @(negedge clk);      // T+5
      if (use_kill) begin
         kill = 1'b1;
      end else begin
         ovr_valid = 1'b1; ovr_rd = 5'd10;
      end
      @(negedge clk);                 // T+6
      kill = 1'b0; ovr_valid = 1'b0;
      check_eq(use_kill ? "kill_busy" : "ovr_busy", {31'd0, busy}, 32'd0);
      check_eq("abort_pending_rd", {27'd0, pending_rd}, 32'd0);
      expect_no_done(use_kill ? "kill_no_done" : "ovr_no_done");
   endtask

   initial begin
      logic [1:0]  ro;
      logic [31:0] rx;
      logic [31:0] ry;
      logic [4:0]  rr;
      rst = 1'b1; start = 1'b0; op = 2'b00; a = 32'd0; b = 32'd0; rd = 5'd0;
      kill = 1'b0; ovr_valid = 1'b0; ovr_rd = 5'd0; ready = 1'b0;
      repeat (2) @(negedge clk);
      check_eq("rst_busy", {31'd0, busy}, 32'd0);
      check_eq("rst_done", {31'd0, done}, 32'd0);
      check_eq("rst_pending", {27'd0, pending_rd}, 32'd0);
      check_eq("rst_result", result, 32'd0);
      check_eq("rst_rd", {27'd0, rd_out}, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Directed cases.
      run_op(2'b00, 32'hFFFF_FFF9, 32'd2, 5'd7, 0);           // DIV -7/2
      run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 5'd7, 0);           // REM -7/2
      run_op(2'b01, 32'd5, 32'd0, 5'd4, 0);                   // DIVU 5/0
      run_op(2'b11, 32'd5, 32'd0, 5'd4, 0);                   // REMU 5/0
      run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 0);   // overflow
      run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 0);
      run_op(2'b00, 32'd100, 32'hFFFF_FFFD, 5'd12, 5);        // held 5 cycles
      run_op(2'b01, 32'd3, 32'd10, 5'd13, 0);                 // early-out class
      run_op(2'b11, 32'd3, 32'd10, 5'd13, 0);
      run_op(2'b01, 32'hFFFF_FFFF, 32'd1, 5'd31, 1);
      run_op(2'b10, 32'h8000_0000, 32'd3, 5'd1, 0);

      // rd == 0 is ignored.
      op = 2'b01; a = 32'd50; b = 32'd5; rd = 5'd0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check_eq("rd0_busy", {31'd0, busy}, 32'd0);
      expect_no_done("rd0_no_done");

      abort_test(1'b0);
      abort_test(1'b1);

      // kill together with ready in DONE: no transfer.
      op = 2'b01; a = 32'd5; b = 32'd0; rd = 5'd3; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check_eq("kr_done", {31'd0, done}, 32'd1);
      kill = 1'b1; ready = 1'b1;
      @(negedge clk);
      kill = 1'b0; ready = 1'b0;
      check_eq("kr_done_low", {31'd0, done}, 32'd0);
      check_eq("kr_busy_low", {31'd0, busy}, 32'd0);

      // Reset at T+10 mid-CALC.
      op = 2'b00; a = 32'h1234_5678; b = 32'd3; rd = 5'd20; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_eq("mrst_busy", {31'd0, busy}, 32'd0);
      check_eq("mrst_done", {31'd0, done}, 32'd0);
      check_eq("mrst_pending", {27'd0, pending_rd}, 32'd0);
      check_eq("mrst_result", result, 32'd0);
      check_eq("mrst_rd", {27'd0, rd_out}, 32'd0);
      expect_no_done("mrst_no_done");

      // Randomized operations across operand classes.
      for (int n = 0; n < 40; n++) begin
         ro = 2'($urandom_range(0, 3));
         rr = 5'($urandom_range(1, 31));
         case ($urandom_range(0, 5))
            0: begin rx = $urandom; ry = 32'd0; end
            1: begin rx = 32'h8000_0000; ry = 32'hFFFF_FFFF; end
            2: begin rx = 32'($urandom_range(0, 200)) - 32'd100;
                     ry = 32'($urandom_range(1, 20)) - 32'd10; end
            3: begin rx = 32'($urandom_range(0, 1000));
                     ry = rx + 32'($urandom_range(1, 1000)); end
            default: begin rx = $urandom; ry = $urandom >> $urandom_range(0, 31); end
         endcase
         run_op(ro, rx, ry, rr, int'($urandom_range(0, 3)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
